// File: rtl/gate_check_pkg.sv
// Shared types and sizing helpers for the gate_checker stimulus engine.
package gate_check_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic int vec_count(input int n_in);
    return 1 << n_in;
  endfunction

  function automatic int cnt_width(input int n_in);
    return n_in + 1;
  endfunction

  // Clamped so an illegal SETTLE still elaborates far enough to hit the range check.
  function automatic int settle_width(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/gate_checker_settle.sv
// Loadable down-counter with zero flag; paces how long each vector is held.
module gate_checker_settle #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_checker.sv
// Exhaustive truth-table checker for a single-output combinational gate.
// Optional macro GATE_CHECKER_STOP_ON_FAIL_EN ends the run on the first mismatch.
module gate_checker
  import gate_check_pkg::*;
#(
  parameter int unsigned                   N_IN   = 1,
  parameter int unsigned                   SETTLE = 2,
  parameter logic [vec_count(N_IN)-1:0]    TRUTH  = 2'b01
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   dut_in,
  input  logic              dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     ok_cnt,
  output logic [N_IN:0]     fail_cnt,
  output logic              first_fail_vld,
  output logic [N_IN-1:0]   first_fail_vec
);

  localparam int unsigned CW = cnt_width(N_IN);
  localparam int unsigned SW = settle_width(SETTLE);

  generate
    if (SETTLE < 1) begin : g_bad_settle
      $fatal(1, "gate_checker: SETTLE must be at least 1");
    end
    if ((N_IN < 1) || (N_IN > 8)) begin : g_bad_n_in
      $fatal(1, "gate_checker: N_IN must be in 1..8");
    end
  endgenerate

  state_e          state, state_d;
  logic [N_IN-1:0] vec_d, ffvec_d;
  logic [CW-1:0]   ok_d, fail_d;
  logic            ffv_d;
  logic            load, settle_zero, exp_bit, match;

  gate_checker_settle #(
    .W (SW)
  ) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (SW'(SETTLE - 1)),
    .en       (state == RUN),
    .zero     (settle_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      dut_in         <= '0;
      ok_cnt         <= '0;
      fail_cnt       <= '0;
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      state          <= state_d;
      dut_in         <= vec_d;
      ok_cnt         <= ok_d;
      fail_cnt       <= fail_d;
      first_fail_vld <= ffv_d;
      first_fail_vec <= ffvec_d;
    end
  end

  always_comb begin
    state_d = state;
    vec_d   = dut_in;
    ok_d    = ok_cnt;
    fail_d  = fail_cnt;
    ffv_d   = first_fail_vld;
    ffvec_d = first_fail_vec;
    load    = 1'b0;
    exp_bit = TRUTH[dut_in];
    // Case equality so an X/Z gate output is scored as a mismatch.
    match   = (dut_out === exp_bit);

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          vec_d   = '0;
          ok_d    = '0;
          fail_d  = '0;
          ffv_d   = 1'b0;
          ffvec_d = '0;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (settle_zero) begin
          if (match) begin
            ok_d = ok_cnt + CW'(1);
          end else begin
            fail_d = fail_cnt + CW'(1);
            if (!first_fail_vld) begin
              ffv_d   = 1'b1;
              ffvec_d = dut_in;
            end
          end
`ifdef GATE_CHECKER_STOP_ON_FAIL_EN
          if ((&dut_in) || !match) state_d = DONE;
`else
          if (&dut_in) state_d = DONE;
`endif
          else begin
            vec_d = dut_in + N_IN'(1);
            load  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (fail_cnt == '0);

endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker: three configurations checked against a truth-table model.
module tb_gate_checker;

  localparam int S1 = 2;
  localparam int S2 = 2;
  localparam int S3 = 3;
  localparam logic [7:0] T3 = 8'b1001_0110;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic start1 = 1'b0, start2 = 1'b0, start3 = 1'b0;
  logic       din1;
  logic [1:0] din2;
  logic [2:0] din3;
  logic dout1, dout2, dout3;
  logic busy1, busy2, busy3, done1, done2, done3, pass1, pass2, pass3;
  logic [1:0] ok1, fail1;
  logic [2:0] ok2, fail2;
  logic [3:0] ok3, fail3;
  logic ffv1, ffv2, ffv3;
  logic       ffvec1;
  logic [1:0] ffvec2;
  logic [2:0] ffvec3;

  logic xmode = 1'b0;
  logic xval = 1'bx;
  logic [7:0] gut3 = T3;

  assign dout1 = (xmode && (din1 == 1'b0)) ? xval : ~din1;
  assign dout2 = |din2;
  assign dout3 = gut3[din3];

  gate_checker #(.N_IN(1), .SETTLE(S1), .TRUTH(2'b01)) u_not (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_in(din1), .dut_out(dout1),
    .busy(busy1), .done(done1), .pass(pass1), .ok_cnt(ok1), .fail_cnt(fail1),
    .first_fail_vld(ffv1), .first_fail_vec(ffvec1));

  gate_checker #(.N_IN(2), .SETTLE(S2), .TRUTH(4'b1000)) u_and (
    .clk(clk), .rst_n(rst_n), .start(start2), .dut_in(din2), .dut_out(dout2),
    .busy(busy2), .done(done2), .pass(pass2), .ok_cnt(ok2), .fail_cnt(fail2),
    .first_fail_vld(ffv2), .first_fail_vec(ffvec2));

  gate_checker #(.N_IN(3), .SETTLE(S3), .TRUTH(T3)) u_rnd (
    .clk(clk), .rst_n(rst_n), .start(start3), .dut_in(din3), .dut_out(dout3),
    .busy(busy3), .done(done3), .pass(pass3), .ok_cnt(ok3), .fail_cnt(fail3),
    .first_fail_vld(ffv3), .first_fail_vec(ffvec3));

  // Reference: walk the truth table, scoring each vector as the spec describes.
  task automatic model(input int n, input logic [255:0] truth, input logic [255:0] gut,
                       output int ok, output int fail, output logic ffv, output int ffvec,
                       output int lastv, output int nsamp);
    ok = 0; fail = 0; ffv = 1'b0; ffvec = 0; lastv = 0; nsamp = 0;
    for (int k = 0; k < (1 << n); k++) begin
      nsamp++;
      lastv = k;
      if (gut[k] === truth[k]) ok++;
      else begin
        fail++;
        if (!ffv) begin ffv = 1'b1; ffvec = k; end
`ifdef GATE_CHECKER_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
  endtask

  function automatic logic get_done(input int id);
    case (id)
      1: return done1;
      2: return done2;
      default: return done3;
    endcase
  endfunction

  task automatic set_start(input int id, input logic v);
    case (id)
      1: start1 = v;
      2: start2 = v;
      default: start3 = v;
    endcase
  endtask

  // Start lands on edge E; returns 1 ns after E.
  task automatic pulse_start(input int id);
    @(negedge clk);
    set_start(id, 1'b1);
    @(posedge clk);
    #1 set_start(id, 1'b0);
  endtask

  task automatic wait_done(input int id, input int max, inout int cycles);
    while (!get_done(id) && cycles < max) begin
      @(posedge clk);
      #1 cycles++;
    end
    if (!get_done(id)) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout dut%0d: done=0 after %0d cycles, required 1", id, cycles);
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({busy1, done1, pass1, ok1, fail1, ffv1, ffvec1, din1} !== '0) begin
      n_bad++; $display("FAIL reset_not: got %b required all zero",
                        {busy1, done1, pass1, ok1, fail1, ffv1, ffvec1, din1});
    end
    n_cmp++;
    if ({busy2, done2, pass2, ok2, fail2, ffv2, ffvec2, din2} !== '0) begin
      n_bad++; $display("FAIL reset_and: got %b required all zero",
                        {busy2, done2, pass2, ok2, fail2, ffv2, ffvec2, din2});
    end
    n_cmp++;
    if ({busy3, done3, pass3, ok3, fail3, ffv3, ffvec3, din3} !== '0) begin
      n_bad++; $display("FAIL reset_rnd: got %b required all zero",
                        {busy3, done3, pass3, ok3, fail3, ffv3, ffvec3, din3});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_not();
    int ok, fail, ffvec, lastv, ns, c;
    logic ffv;
    model(1, 256'b01, 256'b01, ok, fail, ffv, ffvec, lastv, ns);
    c = 0;
    pulse_start(1);
    wait_done(1, 50, c);
    n_cmp++; if (c != S1 * ns) begin n_bad++; $display("FAIL not_latency: got %0d required %0d", c, S1 * ns); end
    n_cmp++; if (int'(ok1) != ok) begin n_bad++; $display("FAIL not_ok: got %0d required %0d", ok1, ok); end
    n_cmp++; if (int'(fail1) != fail) begin n_bad++; $display("FAIL not_fail: got %0d required %0d", fail1, fail); end
    n_cmp++; if (pass1 !== 1'b1) begin n_bad++; $display("FAIL not_pass: got %b required 1", pass1); end
    n_cmp++; if (ffv1 !== 1'b0) begin n_bad++; $display("FAIL not_ffv: got %b required 0", ffv1); end
    n_cmp++; if (int'(din1) != lastv) begin n_bad++; $display("FAIL not_last_vec: got %0d required %0d", din1, lastv); end
  endtask

  task automatic test_faulty_and();
    int ok, fail, ffvec, lastv, ns, c;
    logic ffv;
    model(2, 256'b1000, 256'b1110, ok, fail, ffv, ffvec, lastv, ns);
    c = 0;
    pulse_start(2);
    wait_done(2, 50, c);
    n_cmp++; if (c != S2 * ns) begin n_bad++; $display("FAIL and_latency: got %0d required %0d", c, S2 * ns); end
    n_cmp++; if (int'(ok2) != ok) begin n_bad++; $display("FAIL and_ok: got %0d required %0d", ok2, ok); end
    n_cmp++; if (int'(fail2) != fail) begin n_bad++; $display("FAIL and_fail: got %0d required %0d", fail2, fail); end
    n_cmp++; if (ffv2 !== ffv) begin n_bad++; $display("FAIL and_ffv: got %b required %b", ffv2, ffv); end
    n_cmp++; if (int'(ffvec2) != ffvec) begin n_bad++; $display("FAIL and_ffvec: got %0d required %0d", ffvec2, ffvec); end
    n_cmp++; if (pass2 !== 1'b0) begin n_bad++; $display("FAIL and_pass: got %b required 0", pass2); end
    n_cmp++; if (int'(din2) != lastv) begin n_bad++; $display("FAIL and_last_vec: got %0d required %0d", din2, lastv); end
  endtask

  task automatic test_random();
    int ok, fail, ffvec, lastv, ns, c;
    logic ffv;
    for (int it = 0; it < 8; it++) begin
      gut3 = (it == 0) ? T3 : 8'($urandom);
      model(3, 256'(T3), 256'(gut3), ok, fail, ffv, ffvec, lastv, ns);
      c = 0;
      pulse_start(3);
      wait_done(3, 100, c);
      n_cmp++; if (c != S3 * ns) begin n_bad++; $display("FAIL rnd_latency[%0d]: got %0d required %0d", it, c, S3 * ns); end
      n_cmp++; if (int'(ok3) != ok || int'(fail3) != fail) begin
        n_bad++; $display("FAIL rnd_counts[%0d]: got ok=%0d fail=%0d required ok=%0d fail=%0d", it, ok3, fail3, ok, fail);
      end
      n_cmp++; if (ffv3 !== ffv || (ffv && int'(ffvec3) != ffvec)) begin
        n_bad++; $display("FAIL rnd_first[%0d]: got vld=%b vec=%0d required vld=%b vec=%0d", it, ffv3, ffvec3, ffv, ffvec);
      end
      n_cmp++; if (pass3 !== (fail == 0) || int'(din3) != lastv) begin
        n_bad++; $display("FAIL rnd_end[%0d]: got pass=%b vec=%0d required pass=%b vec=%0d", it, pass3, din3, fail == 0, lastv);
      end
    end
  endtask

  task automatic test_x_output();
    int ok, fail, ffvec, lastv, ns, c;
    logic ffv;
    logic [255:0] g;
    g = '0;
    g[0] = xval;
    xmode = 1'b1;
    model(1, 256'b01, g, ok, fail, ffv, ffvec, lastv, ns);
    c = 0;
    pulse_start(1);
    wait_done(1, 50, c);
    n_cmp++; if (int'(fail1) != fail || int'(ok1) != ok) begin
      n_bad++; $display("FAIL x_counts: got ok=%0d fail=%0d required ok=%0d fail=%0d", ok1, fail1, ok, fail);
    end
    n_cmp++; if (ffv1 !== ffv || int'(ffvec1) != ffvec) begin
      n_bad++; $display("FAIL x_first: got vld=%b vec=%0d required vld=%b vec=%0d", ffv1, ffvec1, ffv, ffvec);
    end
    xmode = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int c;
    gut3 = T3;
    pulse_start(3);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy3, done3, pass3, ok3, fail3, ffv3, ffvec3, din3} !== '0) begin
      n_bad++; $display("FAIL midrun_reset: got %b required all zero",
                        {busy3, done3, pass3, ok3, fail3, ffv3, ffvec3, din3});
    end
    @(negedge clk);
    rst_n = 1'b1;
    c = 0;
    pulse_start(3);
    wait_done(3, 100, c);
    n_cmp++; if (ok3 !== 4'd8 || fail3 !== 4'd0 || c != S3 * 8) begin
      n_bad++; $display("FAIL midrun_rerun: got ok=%0d fail=%0d cyc=%0d required ok=8 fail=0 cyc=%0d", ok3, fail3, c, S3 * 8);
    end
  endtask

  task automatic test_start_handling();
    int ok, fail, ffvec, lastv, ns, c;
    logic ffv;
    gut3 = T3;
    model(3, 256'(T3), 256'(gut3), ok, fail, ffv, ffvec, lastv, ns);
    c = 0;
    pulse_start(3);
    repeat (2) begin @(posedge clk); #1 c++; end
    start3 = 1'b1;
    repeat (2) begin @(posedge clk); #1 c++; end
    start3 = 1'b0;
    wait_done(3, 100, c);
    n_cmp++; if (c != S3 * ns || int'(ok3) != ok) begin
      n_bad++; $display("FAIL start_in_run: got cyc=%0d ok=%0d required cyc=%0d ok=%0d", c, ok3, S3 * ns, ok);
    end
    gut3 = ~T3;
    pulse_start(3);
    n_cmp++;
    if ({busy3, done3, ok3, fail3, ffv3, din3} !== {1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 3'd0}) begin
      n_bad++; $display("FAIL restart_from_done: got busy=%b done=%b ok=%0d fail=%0d vld=%b vec=%0d required 1 0 0 0 0 0",
                        busy3, done3, ok3, fail3, ffv3, din3);
    end
    c = 0;
    wait_done(3, 100, c);
  endtask

  task automatic test_back_to_back();
    int c;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 c = 0;
    wait_done(1, 50, c);
    n_cmp++; if (c != S1 * 2) begin n_bad++; $display("FAIL b2b_first: got %0d required %0d", c, S1 * 2); end
    @(posedge clk);
    #1;
    n_cmp++; if (done1 !== 1'b0 || busy1 !== 1'b1 || din1 !== 1'b0) begin
      n_bad++; $display("FAIL b2b_restart: got done=%b busy=%b vec=%b required 0 1 0", done1, busy1, din1);
    end
    start1 = 1'b0;
    c = 0;
    wait_done(1, 50, c);
    n_cmp++; if (c != S1 * 2 || ok1 !== 2'd2) begin
      n_bad++; $display("FAIL b2b_second: got cyc=%0d ok=%0d required cyc=%0d ok=2", c, ok1, S1 * 2);
    end
  endtask

  initial begin
    test_reset();
    test_not();
    test_faulty_and();
    test_random();
    test_x_output();
    test_reset_mid_run();
    test_start_handling();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gate_checker.md
Name: gate_checker

Overview:
- Synthesizable self-checking stimulus engine for single-output combinational primitives (gate_not, gate_and, ...).
- Drives every input vector of the gate under test (GUT) in ascending order, waits a settle interval and compares the GUT output against a parameterised truth table.
- Counts ok/fail results and captures the first failing vector, so gate checks can run on-chip or inside larger benches without a file log.

Parameters:
- N_IN, 1, number of GUT inputs (1..8); vector count is 2^N_IN.
- SETTLE, 2, clock cycles each vector is held before the output is sampled (≥1).
- TRUTH, 2'b01, expected output per vector; bit k is the expected output for dut_in==k. Width 2^N_IN. The default is the inverter truth table.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- dut_in  out  N_IN  stimulus vector to the GUT.
- dut_out  in  1  GUT output.
- busy  out  1  run in progress.
- done  out  1  run complete; level signal, held until next start or reset.
- pass  out  1  done && fail_cnt==0.
- ok_cnt  out  N_IN+1  number of matching vectors.
- fail_cnt  out  N_IN+1  number of mismatching vectors.
- first_fail_vld  out  1  at least one mismatch recorded.
- first_fail_vec  out  N_IN  vector of the first mismatch.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; dut_in=0; busy=0; done=0; pass=0; ok_cnt=0; fail_cnt=0; first_fail_vld=0; first_fail_vec=0; settle counter=0.
- State machine: IDLE, RUN, DONE.
- IDLE/DONE, start=1 at edge E:
  - state becomes RUN; busy=1; done=0.
  - dut_in=0; both counters and first_fail state cleared.
  - settle counter loaded with SETTLE-1.
- RUN, settle counter ≠ 0: decrement by 1; dut_in held.
- RUN, settle counter = 0, sampling edge:
  - Compare dut_out against TRUTH[dut_in].
  - Match: ok_cnt+1. Mismatch, including X/Z on dut_out: fail_cnt+1.
  - On the first mismatch of the run, also set first_fail_vld=1 and capture first_fail_vec=dut_in.
  - If dut_in = 2^N_IN-1: state becomes DONE; busy=0; done=1; dut_in holds its last value.
  - Otherwise dut_in increments by 1 and the settle counter reloads SETTLE-1.
- Timing:
  - Vector k is applied at edge E+k*SETTLE and sampled at edge E+(k+1)*SETTLE.
  - done rises at edge E+SETTLE*2^N_IN.
- start while in RUN is ignored.
- start held high continuously: the block restarts immediately from DONE. It spends one clean DONE cycle between runs.
- Reset mid-run: immediate return to reset values; no partial results are retained.
- Invariant: ok_cnt+fail_cnt equals the number of vectors sampled so far; it equals 2^N_IN at done. Counter width N_IN+1 covers this without overflow.
- SETTLE=0 is illegal; an elaboration-time check stops the build.

Optional Feature:
- Macro: GATE_CHECKER_STOP_ON_FAIL_EN.
- Defined: the first mismatch moves the FSM straight to DONE on that sampling edge. No further vectors are driven; dut_in holds the failing vector; fail_cnt=1.
- Undefined: all 2^N_IN vectors always run, as described in Behaviour.

Decomposition:
- Shared package gate_check_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Localparam functions: vector count (1<<N_IN), counter width (N_IN+1), settle-counter width ($clog2(SETTLE+1)).
- One natural sub-module, gate_checker_settle: a loadable down-counter with a zero flag.
- FSM, vector register, comparison and counters stay in gate_checker.

Test Plan:
- NOT check: N_IN=1, TRUTH=2'b01, SETTLE=2, GUT=gate_not, start pulse at cycle 0. Expect done at cycle 4, ok_cnt=2, fail_cnt=0, pass=1, first_fail_vld=0.
- Faulty gate: N_IN=2, TRUTH=4'b1000 (AND), GUT wired as OR. Expect ok_cnt=2, fail_cnt=2, first_fail_vld=1, first_fail_vec=2'b01, pass=0.
- Stop-on-fail: same setup built with GATE_CHECKER_STOP_ON_FAIL_EN. Expect done at cycle 2*SETTLE, fail_cnt=1, ok_cnt=1, dut_in=2'b01.
- Reset mid-run: N_IN=3, drop rst_n at cycle 5. Expect all outputs return to reset values asynchronously. A new start gives a full 8-vector run with ok_cnt=8.
- Start handling: start pulsed during RUN is ignored, and done still arrives at cycle SETTLE*2^N_IN. start in DONE clears counters and restarts from dut_in=0.
- X on output: dut_out forced to 1'bx for vector 0. Expect fail_cnt=1, first_fail_vec=0.
